// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed seven-segment display driver.
// Decodes DIGITS hex nibbles to segments a-g and scans them onto a shared
// segment bus with one-hot anodes. New data is committed only at frame
// boundaries (tear-free). Leading-zero blanking, per-digit blank and decimal
// point, and a dead time at the start of each slot to avoid ghosting.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lzb,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_pulse,
  output logic                  pending
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(DIGITS - 1);

  // Electrical "off" levels; XOR-ing an active-high pattern with these
  // applies the pin polarity at the output register.
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
  } frame_t;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  frame_t           shadow;
  frame_t           disp;
  frame_t           incoming;
  logic             tick;
  logic             boundary;

  assign incoming = '{value: value, dp: dp_in, blank: blank_in};
  assign tick     = enable && (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  // Prescaler and digit index; both freeze while enable is low.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture and frame-synchronous commit; a load on the boundary
  // itself bypasses the shadow and lands on the display directly.
  // NOTE: shadow/display are plain registers, reset so that a reset always
  // discards stale digits instead of showing them after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      disp        <= '0;
      pending     <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= boundary;
      if (load) shadow <= incoming;
      if (boundary && load) begin
        disp    <= incoming;
        pending <= 1'b0;
      end else if (boundary && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  logic [3:0]        nib;
  logic              dp_bit;
  logic              blk;
  logic              lz;
  logic              lit;
  logic [6:0]        seg_ah;
  logic              dp_ah;
  logic [DIGITS-1:0] an_ah;

  // Select the current digit, work out leading-zero blanking and build the
  // active-high output pattern.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    blk    = 1'b0;
    an_ah  = '0;
    lz     = lzb && (idx != '0);
    lit    = enable && (cnt >= BLANK_LIM);
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        nib      = disp.value[4*i +: 4];
        dp_bit   = disp.dp[i];
        blk      = disp.blank[i];
        an_ah[i] = lit;
      end
      // Any non-zero nibble at or above the current digit ends the run of
      // leading zeros for it.
      if ((IDX_W'(i) >= idx) && (disp.value[4*i +: 4] != 4'h0)) lz = 1'b0;
    end
    seg_ah = (lit && !blk && !lz) ? decode(nib) : 7'h00;
    dp_ah  = lit && !blk && dp_bit;
  end

  // Registered pins with polarity applied last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_ah ^ SEG_OFF;
      dp  <= dp_ah ^ DP_OFF;
      an  <= an_ah ^ AN_OFF;
    end
  end

endmodule
